// File: rtl/change_dispenser_pkg.sv
// Shared types and denomination constants for the change dispenser.
package change_pkg;

    typedef enum logic [2:0] {
        COIN_NONE     = 3'd0,
        COIN_CIRCLE   = 3'd1,
        COIN_TRIANGLE = 3'd3,
        COIN_PENTAGON = 3'd5
    } coin_t;

    typedef enum logic [1:0] {
        IDLE,
        DISPENSE,
        DONE
    } state_t;

    localparam int unsigned CIRC_VAL = 1;
    localparam int unsigned TRI_VAL  = 3;
    localparam int unsigned PENT_VAL = 5;

endpackage

// File: rtl/change_dispenser_if.sv
// Coin output handshake between the dispenser (master) and the coin mechanism (slave).
interface change_dispenser_if;
    import change_pkg::*;

    logic  coin_valid;
    coin_t coin;
    logic  coin_ready;

    modport master (output coin_valid, output coin, input coin_ready);
    modport slave  (input coin_valid, input coin, output coin_ready);

endinterface

// File: rtl/change_dispenser_coin_select.sv
// Greedy 5->3->1 coin choice from the remaining change and the current inventory.
module coin_select
    import change_pkg::*;
#(
    parameter int unsigned VAL_W = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic [VAL_W-1:0] remaining,
    input  logic [CNT_W-1:0] pent_cnt,
    input  logic [CNT_W-1:0] tri_cnt,
    input  logic [CNT_W-1:0] circ_cnt,
    output coin_t            pick,
    output logic [VAL_W-1:0] value
);

    always_comb begin
        pick  = COIN_NONE;
        value = '0;
        if (remaining >= VAL_W'(PENT_VAL) && pent_cnt != '0) begin
            pick  = COIN_PENTAGON;
            value = VAL_W'(PENT_VAL);
        end else if (remaining >= VAL_W'(TRI_VAL) && tri_cnt != '0) begin
            pick  = COIN_TRIANGLE;
            value = VAL_W'(TRI_VAL);
        end else if (remaining >= VAL_W'(CIRC_VAL) && circ_cnt != '0) begin
            pick  = COIN_CIRCLE;
            value = VAL_W'(CIRC_VAL);
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Sequential change dispenser: latches a cost/paid transaction and hands out change one coin per handshake.
// Optional CHANGE_DISPENSER_STATS_EN adds saturating txn_count/short_count outputs.
module change_dispenser
    import change_pkg::*;
#(
    parameter int unsigned VAL_W     = 8,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned MAX_COINS = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [VAL_W-1:0]    cost,
    input  logic [VAL_W-1:0]    paid,
    input  logic                load_en,
    input  logic [CNT_W-1:0]    load_p,
    input  logic [CNT_W-1:0]    load_t,
    input  logic [CNT_W-1:0]    load_c,
    change_dispenser_if.master  coin_if,
    output logic                busy,
    output logic                done,
    output logic                exact_amount,
    output logic                cough_up_more,
    output logic                not_enough_change,
    output logic [VAL_W-1:0]    remaining,
    output logic [CNT_W-1:0]    pent_cnt,
    output logic [CNT_W-1:0]    tri_cnt,
    output logic [CNT_W-1:0]    circ_cnt
`ifdef CHANGE_DISPENSER_STATS_EN
    ,
    output logic [15:0]         txn_count,
    output logic [15:0]         short_count
`endif
);

    localparam int unsigned SENT_W = $clog2(MAX_COINS + 1);

    state_t            state;
    logic [SENT_W-1:0] coins_sent;
    coin_t             pick;
    logic [VAL_W-1:0]  pick_val;
    logic              coin_valid_c;

    coin_select #(
        .VAL_W (VAL_W),
        .CNT_W (CNT_W)
    ) u_coin_select (
        .remaining (remaining),
        .pent_cnt  (pent_cnt),
        .tri_cnt   (tri_cnt),
        .circ_cnt  (circ_cnt),
        .pick      (pick),
        .value     (pick_val)
    );

    // Offer is decoded straight from registers so it holds steady through a stall.
    assign coin_valid_c       = (state == DISPENSE) && (pick != COIN_NONE) &&
                                (coins_sent < SENT_W'(MAX_COINS));
    assign coin_if.coin_valid = coin_valid_c;
    assign coin_if.coin       = coin_valid_c ? pick : COIN_NONE;
    assign busy               = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            coins_sent        <= '0;
            done              <= 1'b0;
            exact_amount      <= 1'b0;
            cough_up_more     <= 1'b0;
            not_enough_change <= 1'b0;
            remaining         <= '0;
            pent_cnt          <= '0;
            tri_cnt           <= '0;
            circ_cnt          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_en) begin
                        pent_cnt <= load_p;
                        tri_cnt  <= load_t;
                        circ_cnt <= load_c;
                    end else if (start) begin
                        exact_amount      <= 1'b0;
                        cough_up_more     <= 1'b0;
                        not_enough_change <= 1'b0;
                        coins_sent        <= '0;
                        if (paid < cost) begin
                            cough_up_more <= 1'b1;
                            remaining     <= '0;
                            state         <= DONE;
                            done          <= 1'b1;
                        end else if (paid == cost) begin
                            exact_amount <= (paid != '0) && (cost != '0);
                            remaining    <= '0;
                            state        <= DONE;
                            done         <= 1'b1;
                        end else begin
                            remaining <= paid - cost;
                            state     <= DISPENSE;
                        end
                    end
                end
                DISPENSE: begin
                    if (coin_valid_c) begin
                        if (coin_if.coin_ready) begin
                            remaining  <= remaining - pick_val;
                            coins_sent <= coins_sent + SENT_W'(1);
                            case (pick)
                                COIN_PENTAGON: pent_cnt <= pent_cnt - CNT_W'(1);
                                COIN_TRIANGLE: tri_cnt  <= tri_cnt - CNT_W'(1);
                                COIN_CIRCLE:   circ_cnt <= circ_cnt - CNT_W'(1);
                                default: ;
                            endcase
                        end
                    end else begin
                        not_enough_change <= (remaining != '0);
                        state             <= DONE;
                        done              <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CHANGE_DISPENSER_STATS_EN
    // Transaction statistics, saturating at all-ones.
    always_ff @(posedge clock) begin
        if (reset) begin
            txn_count   <= '0;
            short_count <= '0;
        end else if (done) begin
            if (txn_count != 16'hFFFF) begin
                txn_count <= txn_count + 16'd1;
            end
            if (not_enough_change && short_count != 16'hFFFF) begin
                short_count <= short_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: arithmetic greedy model feeds queues, a negedge monitor checks.
module tb_change_dispenser;
    import change_pkg::*;

    localparam int unsigned VAL_W     = 8;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned MAX_COINS = 4;

    logic             clock = 1'b0;
    logic             reset, start, load_en;
    logic [VAL_W-1:0] cost, paid, remaining;
    logic [CNT_W-1:0] load_p, load_t, load_c, pent_cnt, tri_cnt, circ_cnt;
    logic             busy, done, exact_amount, cough_up_more, not_enough_change;
`ifdef CHANGE_DISPENSER_STATS_EN
    logic [15:0]      txn_count, short_count;
`endif

    change_dispenser_if cif();

    always #5 clock = ~clock;

    change_dispenser #(
        .VAL_W     (VAL_W),
        .CNT_W     (CNT_W),
        .MAX_COINS (MAX_COINS)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .cost              (cost),
        .paid              (paid),
        .load_en           (load_en),
        .load_p            (load_p),
        .load_t            (load_t),
        .load_c            (load_c),
        .coin_if           (cif),
        .busy              (busy),
        .done              (done),
        .exact_amount      (exact_amount),
        .cough_up_more     (cough_up_more),
        .not_enough_change (not_enough_change),
        .remaining         (remaining),
        .pent_cnt          (pent_cnt),
        .tri_cnt           (tri_cnt),
        .circ_cnt          (circ_cnt)
`ifdef CHANGE_DISPENSER_STATS_EN
        ,
        .txn_count         (txn_count),
        .short_count       (short_count)
`endif
    );

    typedef struct {
        bit dispense;
        bit under;
        bit exact;
        bit nec;
        int rem;
        int p;
        int t;
        int c;
        int ncoins;
    } res_t;

    res_t exp_res_q[$];
    int   exp_coin_q[$];

    int n_checks = 0, n_pass = 0;
    int n_done_seen = 0, n_coins_seen = 0;
    int rst_req = 0, rst_seen = 0, to_req = 0, to_seen = 0;
    int mdl_p = 0, mdl_t = 0, mdl_c = 0;

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s got=%0d expected=%0d", name, got, want);
    endtask

    // Monitor / scoreboard
    bit               pend_first, pend_load, prev_valid, prev_ready, prev_done;
    res_t             first_res, r_done;
    logic [CNT_W-1:0] lp, lt, lc, prev_p, prev_t, prev_c;
    logic [2:0]       prev_coin;
    int               st_txn = 0, st_short = 0;

    always @(negedge clock) begin
        if (reset) begin
            pend_first = 0;
            pend_load  = 0;
            prev_valid = 0;
            prev_ready = 0;
            prev_done  = 0;
            st_txn     = 0;
            st_short   = 0;
        end else begin
            if (rst_req != rst_seen) begin
                rst_seen = rst_req;
                chk("reset_ctrl", 32'({busy, done, exact_amount, cough_up_more, not_enough_change,
                                       cif.coin_valid, 3'(cif.coin)}), 0);
                chk("reset_regs", int'(remaining) + int'(pent_cnt) + int'(tri_cnt) + int'(circ_cnt), 0);
            end
            if (to_req != to_seen) begin
                to_seen = to_req;
                n_checks++;
                $display("FAIL txn_timeout no done pulse, done_seen=%0d", n_done_seen);
            end
            if (prev_valid && !prev_ready)
                chk("stall_hold", 32'({cif.coin_valid, 3'(cif.coin), pent_cnt, tri_cnt, circ_cnt}),
                    32'({1'b1, prev_coin, prev_p, prev_t, prev_c}));
            if (pend_first) begin
                pend_first = 0;
                chk("first_cycle", 32'({busy, done, cif.coin_valid}),
                    32'({1'b1, !first_res.dispense, first_res.ncoins > 0}));
            end
            if (start && !load_en && !busy && exp_res_q.size() > 0) begin
                first_res  = exp_res_q[0];
                pend_first = 1;
            end
            if (pend_load) begin
                pend_load = 0;
                chk("load_applied", 32'({busy, pent_cnt, tri_cnt, circ_cnt}), 32'({1'b0, lp, lt, lc}));
            end
            if (load_en && !busy) begin
                pend_load = 1;
                lp = load_p;
                lt = load_t;
                lc = load_c;
            end
            if (cif.coin_valid && cif.coin_ready) begin
                n_coins_seen++;
                if (exp_coin_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_coin got=%0d expected=none", int'(cif.coin));
                end else begin
                    chk("coin", int'(cif.coin), exp_coin_q.pop_front());
                end
            end
`ifdef CHANGE_DISPENSER_STATS_EN
            if (prev_done) begin
                chk("txn_count", int'(txn_count), st_txn);
                chk("short_count", int'(short_count), st_short);
            end
`endif
            if (done) begin
                n_done_seen++;
                if (exp_res_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_done got=1 expected=0");
                end else begin
                    r_done = exp_res_q.pop_front();
                    chk("flags", int'(cough_up_more) * 4 + int'(exact_amount) * 2 + int'(not_enough_change),
                        int'(r_done.under) * 4 + int'(r_done.exact) * 2 + int'(r_done.nec));
                    chk("remaining", int'(remaining), r_done.rem);
                    chk("inventory", int'(pent_cnt) * 256 + int'(tri_cnt) * 16 + int'(circ_cnt),
                        r_done.p * 256 + r_done.t * 16 + r_done.c);
                    chk("coin_idle", 32'({cif.coin_valid, 3'(cif.coin)}), 0);
                end
                st_txn++;
                if (not_enough_change) st_short++;
            end
            prev_done  = done;
            prev_valid = cif.coin_valid;
            prev_ready = cif.coin_ready;
            prev_coin  = cif.coin;
            prev_p     = pent_cnt;
            prev_t     = tri_cnt;
            prev_c     = circ_cnt;
        end
    end

    // Stimulus
    function automatic int min3(input int a, input int b, input int c);
        int m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        start          = 1'b0;
        load_en        = 1'b0;
        cif.coin_ready = 1'b0;
        tick();
        reset = 1'b0;
        exp_res_q.delete();
        exp_coin_q.delete();
        mdl_p = 0;
        mdl_t = 0;
        mdl_c = 0;
        rst_req++;
        tick();
    endtask

    task automatic do_load(input int p, input int t, input int c);
        load_en = 1'b1;
        load_p  = CNT_W'(p);
        load_t  = CNT_W'(t);
        load_c  = CNT_W'(c);
        tick();
        load_en = 1'b0;
        mdl_p = p;
        mdl_t = t;
        mdl_c = c;
        tick();
    endtask

    // Greedy change with a coin budget, counted per denomination.
    task automatic expect_txn(input int c_, input int p_);
        res_t r;
        int   rem, quota, n5, n3, n1;
        r = '{default: 0};
        if (p_ < c_) begin
            r.under = 1;
        end else if (p_ == c_) begin
            r.exact = (p_ != 0 && c_ != 0);
        end else begin
            r.dispense = 1;
            rem   = p_ - c_;
            quota = int'(MAX_COINS);
            n5 = min3(rem / 5, mdl_p, quota);
            rem -= 5 * n5; mdl_p -= n5; quota -= n5;
            n3 = min3(rem / 3, mdl_t, quota);
            rem -= 3 * n3; mdl_t -= n3; quota -= n3;
            n1 = min3(rem, mdl_c, quota);
            rem -= n1; mdl_c -= n1;
            repeat (n5) exp_coin_q.push_back(5);
            repeat (n3) exp_coin_q.push_back(3);
            repeat (n1) exp_coin_q.push_back(1);
            r.rem    = rem;
            r.nec    = (rem != 0);
            r.ncoins = n5 + n3 + n1;
        end
        r.p = mdl_p;
        r.t = mdl_t;
        r.c = mdl_c;
        exp_res_q.push_back(r);
    endtask

    task automatic run_txn(input int c_, input int p_, input int stall, input int pct, input bit noise);
        int d0, k;
        expect_txn(c_, p_);
        cost  = VAL_W'(c_);
        paid  = VAL_W'(p_);
        start = 1'b1;
        d0    = n_done_seen;
        tick();
        start = 1'b0;
        k     = 0;
        while (n_done_seen == d0 && k < 200) begin
            cif.coin_ready = (k < stall) ? 1'b0 : (int'($urandom_range(0, 99)) < pct);
            if (noise) begin
                start   = ($urandom_range(0, 3) == 0);
                load_en = ($urandom_range(0, 3) == 0);
                load_p  = CNT_W'($urandom);
                cost    = VAL_W'($urandom);
            end
            tick();
            k++;
        end
        start          = 1'b0;
        load_en        = 1'b0;
        cif.coin_ready = 1'b0;
        if (n_done_seen == d0) begin
            to_req++;
            exp_res_q.delete();
            exp_coin_q.delete();
        end
        tick();
    endtask

    initial begin
        int c0, k, cst, pd, mode;
        int pcts[3] = '{100, 50, 25};
        reset = 1'b1; start = 1'b0; load_en = 1'b0;
        cost = '0; paid = '0; load_p = '0; load_t = '0; load_c = '0;
        cif.coin_ready = 1'b0;
        tick();
        do_reset();

        do_load(2, 2, 2);
        run_txn(3, 11, 0, 100, 1'b1);
        do_load(2, 2, 2);
        run_txn(3, 11, 3, 100, 1'b0);
        run_txn(5, 2, 0, 100, 1'b0);
        run_txn(7, 7, 0, 100, 1'b0);
        run_txn(0, 0, 0, 100, 1'b0);
        do_load(0, 1, 1);
        run_txn(0, 7, 0, 100, 1'b0);
        do_load(0, 0, 9);
        run_txn(0, 6, 0, 100, 1'b0);

        // Abort after the first accepted coin
        do_load(2, 2, 2);
        expect_txn(3, 11);
        cost  = VAL_W'(3);
        paid  = VAL_W'(11);
        start = 1'b1;
        c0    = n_coins_seen;
        tick();
        start          = 1'b0;
        cif.coin_ready = 1'b1;
        k              = 0;
        while (n_coins_seen == c0 && k < 20) begin
            tick();
            k++;
        end
        if (n_coins_seen == c0) to_req++;
        do_reset();
        do_load(1, 1, 1);
        run_txn(1, 10, 0, 100, 1'b0);

        // Load and start together: load wins
        load_en = 1'b1;
        start   = 1'b1;
        load_p  = CNT_W'(3);
        load_t  = CNT_W'(3);
        load_c  = CNT_W'(3);
        cost    = VAL_W'(0);
        paid    = VAL_W'(20);
        tick();
        load_en = 1'b0;
        start   = 1'b0;
        mdl_p = 3; mdl_t = 3; mdl_c = 3;
        tick();
        tick();

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0)
                do_load(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                        int'($urandom_range(0, 15)));
            cst  = int'($urandom_range(0, 60));
            mode = int'($urandom_range(0, 5));
            if (mode == 0)      pd = int'($urandom_range(0, cst));
            else if (mode == 1) pd = cst;
            else                pd = cst + int'($urandom_range(1, 40));
            run_txn(cst, pd, int'($urandom_range(0, 2)), pcts[$urandom_range(0, 2)],
                    ($urandom_range(0, 1) == 1));
        end

        tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Sequential, parametrised successor to the combinational change machine. Latches a Cost/Paid transaction, computes change, and dispenses it one coin per handshake from a registered coin inventory (pentagon = 5, triangle = 3, circle = 1), using greedy 5→3→1 selection. Dispensing stops at a configurable per-transaction coin limit. Inventory is decremented only on accepted coins. It sits between the payment front end and the coin-output mechanism.

## Interface
- VAL_W, 8: width of cost, paid, remaining.
- CNT_W, 4: width of each inventory counter.
- MAX_COINS, 4: maximum coins dispensed per transaction (≥1).
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin transaction; sampled only in IDLE.
- cost  in  VAL_W  price, unsigned.
- paid  in  VAL_W  amount paid, unsigned.
- load_en  in  1  overwrite inventory; honoured only in IDLE.
- load_p / load_t / load_c  in  CNT_W each  new pentagon/triangle/circle counts.
- coin_ready  in  1  sink accepts coin this cycle.
- coin_valid  out  1  coin output holds a coin.
- coin  out  3  coin code 0/1/3/5; 0 when coin_valid is low.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse ending a transaction.
- exact_amount / cough_up_more / not_enough_change  out  1 each  result flags.
- remaining  out  VAL_W  undispensed change.
- pent_cnt / tri_cnt / circ_cnt  out  CNT_W each  current inventory.

## Operation
- States: IDLE, DISPENSE, DONE.
- IDLE, load_en=1: inventory ← load values. Same-cycle start is ignored (load wins).
- IDLE, start=1, load_en=0:
  - Clear all flags and coin counter; latch the comparison.
  - paid<cost: cough_up_more←1, remaining←0, go DONE.
  - paid==cost: exact_amount←(paid≠0 && cost≠0), remaining←0, go DONE.
  - paid>cost: remaining←paid−cost (VAL_W unsigned), go DISPENSE.
- DISPENSE, pick from sub-module coin_select:
  - Pentagon if remaining≥5 and pent_cnt>0.
  - Else triangle if remaining≥3 and tri_cnt>0.
  - Else circle if remaining≥1 and circ_cnt>0.
  - Else none. Coin values are zero-extended to VAL_W.
- coin_valid = (pick≠none) && (coins_sent<MAX_COINS).
- On coin_valid && coin_ready:
  - remaining −= value.
  - Matching counter −1.
  - coins_sent +1.
  - Stay in DISPENSE.
- When coin_valid=0 in DISPENSE: not_enough_change←(remaining≠0), go DONE.
- DONE: done=1 for one cycle, then IDLE.
- Flags and remaining hold until the next accepted start or reset.
- start while busy is ignored. load_en while busy is ignored.
- Inventory never underflows: a coin is offered only when its count is >0.

## Timing
- Reset: state IDLE; inventory 0; all flags 0; remaining 0; coin_valid 0; coin 0; done 0; coins_sent 0.
- Reset mid-transaction aborts the transaction immediately and clears the inventory.
- Zero-change transaction: start at edge N → DONE during cycle N+1 (done=1) → IDLE at N+2.
- Change transaction: DISPENSE entered one cycle after start.
  - First coin_valid is in that same cycle (decoded from registers).
  - Each accepted coin costs one cycle.
  - DONE follows one cycle after the last transfer.
- Handshake: coin and coin_valid are stable while coin_valid=1 and coin_ready=0. Transfer occurs at the edge where both are high.
- Back-to-back transfers with coin_ready held high give one coin per cycle.
- coin_ready is ignored when coin_valid=0.

## Configuration
- CHANGE_DISPENSER_STATS_EN defined adds two outputs, each 16-bit and saturating at 0xFFFF, cleared by reset:
  - txn_count: increments on every done pulse.
  - short_count: increments on done when not_enough_change=1.
- Undefined: these ports and counters are absent. All other behaviour is identical.

## Structure
- Package change_pkg holds:
  - coin_t: COIN_NONE=3'd0, COIN_CIRCLE=3'd1, COIN_TRIANGLE=3'd3, COIN_PENTAGON=3'd5.
  - state_t: IDLE, DISPENSE, DONE.
  - Denomination value constants.
- Sub-module coin_select is combinational.
  - Inputs: remaining and the three counts.
  - Outputs: coin_t and its VAL_W value.
- Top level holds the FSM, inventory, remaining and coins_sent registers.

## Test plan
- Change 8, full inventory: load P=2,T=2,C=2; cost=3, paid=11; coin_ready=1 → coins 5, 3; remaining 0; counts 1,1,2; not_enough_change=0; done.
- Stall: same setup with coin_ready low for 3 cycles → coin=5 held stable; inventory unchanged until ready rises.
- Underpay: cost=5, paid=2 → cough_up_more=1, no coin_valid, done one cycle after start. Equal case cost=paid=7 → exact_amount=1. Case cost=paid=0 → exact_amount=0.
- Short inventory: P=0,T=1,C=1, change 7 → coins 3, 1; remaining 3; not_enough_change=1.
- Coin limit: P=0,T=0,C=9, change 6, MAX_COINS=4 → four coins of 1; remaining 2; not_enough_change=1; circ_cnt=5.
- Reset mid-DISPENSE after the first coin → all outputs at reset values next cycle. A following load and start behave normally. Also check start and load_en in the same cycle → load applied, no transaction.
